// File: rtl/spi_master_param.sv
// rtl/spi_master_param.sv - parametrised SPI master, all CPOL/CPHA modes, N chip selects
// Optional feature macro: SPI_LOOPBACK_EN adds p_loopback (receive path samples internal mosi).
module spi_master_param #(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_CS     = 4,
    parameter int CLK_DIV    = 2,
    parameter int CS_W       = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  p_start,
    output logic                  p_ready,
    input  logic [DATA_WIDTH-1:0] p_data_in,
    output logic [DATA_WIDTH-1:0] p_data_out,
    output logic                  p_done,
    input  logic [CS_W-1:0]       p_cs_sel,
    input  logic                  p_cpol,
    input  logic                  p_cpha,
    output logic                  sck,
    output logic                  mosi,
    input  logic                  miso,
`ifdef SPI_LOOPBACK_EN
    input  logic                  p_loopback,
`endif
    output logic [NUM_CS-1:0]     cs
);

    localparam int DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int EDGE_W = $clog2(2 * DATA_WIDTH);
    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLK_DIV - 1);
    localparam logic [EDGE_W-1:0] EDGE_LAST = EDGE_W'(2 * DATA_WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETUP,
        S_SHIFT,
        S_HOLD
    } state_t;

    state_t                state_q, state_d;
    logic [DIV_W-1:0]      div_q, div_d;
    logic [EDGE_W-1:0]     edge_q, edge_d;
    logic [DATA_WIDTH-1:0] tx_q, tx_d;
    logic [DATA_WIDTH-1:0] rx_q, rx_d;
    logic [DATA_WIDTH-1:0] dout_q, dout_d;
    logic                  done_q, done_d;
    logic                  sck_q, sck_d;
    logic                  mosi_q, mosi_d;
    logic [NUM_CS-1:0]     cs_q, cs_d;
    logic                  cpol_q, cpol_d;
    logic                  cpha_q, cpha_d;

    logic                  miso_s;
    logic [NUM_CS-1:0]     cs_dec;
    logic                  tick;
    logic                  sample_edge;
    logic                  last_edge;

`ifdef SPI_LOOPBACK_EN
    assign miso_s = p_loopback ? mosi_q : miso;
`else
    assign miso_s = miso;
`endif

    // One-hot-low decode of the requested select; out-of-range leaves all high
    always_comb begin
        cs_dec = '1;
        for (int i = 0; i < NUM_CS; i++) begin
            if (32'(p_cs_sel) == i) begin
                cs_dec[i] = 1'b0;
            end
        end
    end

    // edge_q counts SCK edges already made; the edge about to happen is leading when edge_q is even
    assign tick        = (div_q == DIV_LAST);
    assign sample_edge = (~edge_q[0]) ^ cpha_q;
    assign last_edge   = (edge_q == EDGE_LAST);

    // Next-state and datapath: every phase is a CLK_DIV-cycle slot; SETUP's expiry makes SCK edge 1
    always_comb begin
        state_d = state_q;
        div_d   = div_q + 1'b1;
        edge_d  = edge_q;
        tx_d    = tx_q;
        rx_d    = rx_q;
        dout_d  = dout_q;
        done_d  = 1'b0;
        sck_d   = sck_q;
        mosi_d  = mosi_q;
        cs_d    = cs_q;
        cpol_d  = cpol_q;
        cpha_d  = cpha_q;

        case (state_q)
            S_IDLE: begin
                div_d = '0;
                sck_d = p_cpol;
                if (p_start) begin
                    tx_d    = p_data_in;
                    mosi_d  = p_data_in[DATA_WIDTH-1];
                    cs_d    = cs_dec;
                    cpol_d  = p_cpol;
                    cpha_d  = p_cpha;
                    edge_d  = '0;
                    state_d = S_SETUP;
                end
            end
            S_SETUP, S_SHIFT: begin
                if (tick) begin
                    div_d  = '0;
                    sck_d  = ~sck_q;
                    edge_d = edge_q + 1'b1;
                    if (sample_edge) begin
                        rx_d = {rx_q[DATA_WIDTH-2:0], miso_s};
                    end else if (!cpha_q) begin
                        // trailing edge in CPHA=0: advance to the next bit unless the word is done
                        if (!last_edge) begin
                            tx_d   = {tx_q[DATA_WIDTH-2:0], 1'b0};
                            mosi_d = tx_q[DATA_WIDTH-2];
                        end
                    end else begin
                        // leading edge in CPHA=1: the first one re-presents the MSB already on the line
                        if (edge_q != '0) begin
                            tx_d   = {tx_q[DATA_WIDTH-2:0], 1'b0};
                            mosi_d = tx_q[DATA_WIDTH-2];
                        end else begin
                            mosi_d = tx_q[DATA_WIDTH-1];
                        end
                    end
                    if (state_q == S_SETUP) begin
                        state_d = S_SHIFT;
                    end else if (last_edge) begin
                        state_d = S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                if (tick) begin
                    div_d   = '0;
                    cs_d    = '1;
                    done_d  = 1'b1;
                    dout_d  = rx_q;
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
                div_d   = '0;
                cs_d    = '1;
            end
        endcase
    end

    // State and datapath registers; reset aborts any transfer without a done pulse
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            div_q   <= '0;
            edge_q  <= '0;
            tx_q    <= '0;
            rx_q    <= '0;
            dout_q  <= '0;
            done_q  <= 1'b0;
            sck_q   <= 1'b0;
            mosi_q  <= 1'b0;
            cs_q    <= '1;
            cpol_q  <= 1'b0;
            cpha_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            edge_q  <= edge_d;
            tx_q    <= tx_d;
            rx_q    <= rx_d;
            dout_q  <= dout_d;
            done_q  <= done_d;
            sck_q   <= sck_d;
            mosi_q  <= mosi_d;
            cs_q    <= cs_d;
            cpol_q  <= cpol_d;
            cpha_q  <= cpha_d;
        end
    end

    assign p_ready    = (state_q == S_IDLE);
    assign p_done     = done_q;
    assign p_data_out = dout_q;
    assign sck        = sck_q;
    assign mosi       = mosi_q;
    assign cs         = cs_q;

endmodule

// File: tb/tb_spi_master_param.sv
// tb/tb_spi_master_param.sv - self-checking bench for spi_master_param with an SPI slave model
module tb_spi_master_param;

    localparam int W      = 8;
    localparam int NCS    = 4;
    localparam int D      = 2;
    localparam int CSW    = 3;
    localparam int T_DONE = 1 + (2 * W + 1) * D;
`ifdef SPI_LOOPBACK_EN
    localparam logic HAS_LB = 1'b1;
`else
    localparam logic HAS_LB = 1'b0;
`endif

    logic           clock = 1'b0;
    logic           reset = 1'b0;
    logic           p_start = 1'b0;
    logic           p_ready;
    logic [W-1:0]   p_data_in = '0;
    logic [W-1:0]   p_data_out;
    logic           p_done;
    logic [CSW-1:0] p_cs_sel = '0;
    logic           p_cpol = 1'b0;
    logic           p_cpha = 1'b0;
    logic           sck;
    logic           mosi;
    logic           miso = 1'b0;
    logic [NCS-1:0] cs;
`ifdef SPI_LOOPBACK_EN
    logic           p_loopback = 1'b0;
`endif

    int ncomp = 0;
    int nfail = 0;

    always #5 clock = ~clock;

    spi_master_param #(
        .DATA_WIDTH(W),
        .NUM_CS(NCS),
        .CLK_DIV(D),
        .CS_W(CSW)
    ) dut (
        .clock(clock),
        .reset(reset),
        .p_start(p_start),
        .p_ready(p_ready),
        .p_data_in(p_data_in),
        .p_data_out(p_data_out),
        .p_done(p_done),
        .p_cs_sel(p_cs_sel),
        .p_cpol(p_cpol),
        .p_cpha(p_cpha),
        .sck(sck),
        .mosi(mosi),
        .miso(miso),
`ifdef SPI_LOOPBACK_EN
        .p_loopback(p_loopback),
`endif
        .cs(cs)
    );

    // SPI slave model: framed by any chip select, behaves per the configured mode
    logic         s_act = 1'b0;
    logic         s_cpol = 1'b0;
    logic         s_cpha = 1'b0;
    logic [W-1:0] s_tx = '0;
    logic [W-1:0] s_rx = '0;
    int           s_idx = 0;
    logic [W-1:0] stxq[$];
    logic [W-1:0] srxq[$];

    always @(cs) begin
        if (cs !== '1 && !s_act) begin
            s_act = 1'b1;
            s_tx  = (stxq.size() > 0) ? stxq.pop_front() : '0;
            s_idx = 0;
            s_rx  = '0;
            miso  = s_tx[W-1];
        end else if (cs === '1 && s_act) begin
            s_act = 1'b0;
            srxq.push_back(s_rx);
        end
    end

    always @(sck) begin
        if (s_act) begin
            if ((sck != s_cpol) ^ s_cpha) begin
                s_rx = {s_rx[W-2:0], mosi};
            end else if (s_cpha) begin
                if (s_idx < W) miso = s_tx[W-1-s_idx];
                s_idx++;
            end else begin
                s_idx++;
                if (s_idx < W) miso = s_tx[W-1-s_idx];
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncomp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic run_xfer(input logic [W-1:0] tx, input logic [W-1:0] stx, input int sel,
                            input logic cpol, input logic cpha, input logic lb,
                            input logic pulse_mid, input string tag);
        int             done_cyc;
        int             ndone;
        int             cs_bad;
        int             nedge;
        logic           prev_sck;
        logic           rdy_done;
        logic [W-1:0]   dout;
        logic [NCS-1:0] exp_cs;
        logic [W-1:0]   rxw;
        exp_cs = (sel < NCS) ? ~(NCS'(1) << sel) : '1;
        @(negedge clock);
        p_cpol    = cpol;
        p_cpha    = cpha;
        p_cs_sel  = CSW'(sel);
        p_data_in = tx;
        s_cpol    = cpol;
        s_cpha    = cpha;
`ifdef SPI_LOOPBACK_EN
        p_loopback = lb;
`endif
        if (sel < NCS) stxq.push_back(stx);
        @(negedge clock);
        @(negedge clock);
        check({tag, " sck_idle"}, 32'(sck), 32'(cpol));
        check({tag, " ready_pre"}, 32'(p_ready), 32'd1);
        p_start = 1'b1;
        @(negedge clock);
        p_start  = 1'b0;
        done_cyc = 0;
        ndone    = 0;
        cs_bad   = 0;
        nedge    = 0;
        prev_sck = cpol;
        rdy_done = 1'b0;
        dout     = '0;
        for (int c = 1; c <= T_DONE + 12; c++) begin
            if (c > 1) @(negedge clock);
            if (pulse_mid && c == 10) p_start = 1'b1;
            if (pulse_mid && c == 11) p_start = 1'b0;
            if (sck !== prev_sck) nedge++;
            prev_sck = sck;
            if (p_done === 1'b1) begin
                ndone++;
                if (done_cyc == 0) done_cyc = c;
            end
            if (c < T_DONE && cs !== exp_cs) cs_bad++;
            if (c >= T_DONE && cs !== '1) cs_bad++;
            if (c == T_DONE) begin
                rdy_done = p_ready;
                dout     = p_data_out;
            end
        end
        check({tag, " done_cycle"}, 32'(done_cyc), 32'(T_DONE));
        check({tag, " done_count"}, 32'(ndone), 32'd1);
        check({tag, " cs_pattern_bad"}, 32'(cs_bad), 32'd0);
        check({tag, " ready_at_done"}, 32'(rdy_done), 32'd1);
        check({tag, " sck_edges"}, 32'(nedge), 32'(2 * W));
        check({tag, " sck_end"}, 32'(sck), 32'(cpol));
        if (sel < NCS || lb) begin
            check({tag, " data_out"}, 32'(dout), 32'(lb ? tx : stx));
        end
        if (sel < NCS) begin
            check({tag, " slave_frames"}, 32'(srxq.size()), 32'd1);
            rxw = (srxq.size() > 0) ? srxq.pop_front() : 'x;
            check({tag, " slave_rx_mosi"}, 32'(rxw), 32'(tx));
        end
        srxq.delete();
`ifdef SPI_LOOPBACK_EN
        p_loopback = 1'b0;
`endif
    endtask

    initial begin
        int d1;
        int d2;
        int nd;
        int cs_hi;
        logic [W-1:0] s1;
        logic [W-1:0] s2;
        logic [W-1:0] o1;
        logic [W-1:0] o2;
        logic [W-1:0] rw;
        int           mode;

        #1 reset = 1'b1;
        repeat (3) @(negedge clock);
        check("rst cs", 32'(cs), 32'hF);
        check("rst sck", 32'(sck), 32'd0);
        check("rst mosi", 32'(mosi), 32'd0);
        check("rst ready", 32'(p_ready), 32'd1);
        check("rst done", 32'(p_done), 32'd0);
        check("rst data_out", 32'(p_data_out), 32'd0);
        reset = 1'b0;
        repeat (10) @(negedge clock);
        check("idle cs", 32'(cs), 32'hF);
        check("idle ready", 32'(p_ready), 32'd1);
        check("idle sck", 32'(sck), 32'd0);
        check("idle done", 32'(p_done), 32'd0);
        srxq.delete();

        run_xfer(8'hE9, 8'h5A, 1, 1'b0, 1'b0, 1'b0, 1'b0, "mode0");
        run_xfer(8'hE9, W'($urandom()), 0, 1'b0, 1'b1, HAS_LB, 1'b0, "mode1");
        run_xfer(8'hE9, W'($urandom()), 2, 1'b1, 1'b0, HAS_LB, 1'b0, "mode2");
        run_xfer(8'hE9, W'($urandom()), 3, 1'b1, 1'b1, HAS_LB, 1'b0, "mode3");

        // back-to-back with p_start held through the first done
        s1 = W'($urandom());
        s2 = W'($urandom());
        @(negedge clock);
        p_cpol = 1'b0; p_cpha = 1'b0; p_cs_sel = 3'd0; p_data_in = 8'hE9;
        s_cpol = 1'b0; s_cpha = 1'b0;
        stxq.push_back(s1);
        stxq.push_back(s2);
        @(negedge clock);
        @(negedge clock);
        p_start = 1'b1;
        @(negedge clock);
        p_data_in = 8'h17;
        d1 = 0; d2 = 0; nd = 0; cs_hi = 0; o1 = '0; o2 = '0;
        for (int c = 1; c <= 2 * T_DONE + 10; c++) begin
            if (c > 1) @(negedge clock);
            if (c == T_DONE + 1) p_start = 1'b0;
            if (p_done === 1'b1) begin
                nd++;
                if (d1 == 0) begin d1 = c; o1 = p_data_out; end
                else if (d2 == 0) begin d2 = c; o2 = p_data_out; end
            end
            if (c < 2 * T_DONE && cs === '1) cs_hi++;
        end
        check("b2b done1_cycle", 32'(d1), 32'(T_DONE));
        check("b2b done_spacing", 32'(d2 - d1), 32'(T_DONE));
        check("b2b done_count", 32'(nd), 32'd2);
        check("b2b cs_high_gap", 32'(cs_hi), 32'd1);
        check("b2b data1", 32'(o1), 32'(s1));
        check("b2b data2", 32'(o2), 32'(s2));
        check("b2b slave_frames", 32'(srxq.size()), 32'd2);
        rw = (srxq.size() > 0) ? srxq.pop_front() : 'x;
        check("b2b slave_rx1", 32'(rw), 32'hE9);
        rw = (srxq.size() > 0) ? srxq.pop_front() : 'x;
        check("b2b slave_rx2", 32'(rw), 32'h17);
        srxq.delete();

        run_xfer(W'($urandom()), W'($urandom()), 2, 1'b0, 1'b0, 1'b0, 1'b1, "ignore_start");
        run_xfer(W'($urandom()), W'($urandom()), 5, 1'b0, 1'b0, 1'b0, 1'b0, "sel_out_of_range");

        // asynchronous reset in the middle of a transfer
        @(negedge clock);
        p_cpol = 1'b0; p_cpha = 1'b0; p_cs_sel = 3'd3; p_data_in = W'($urandom());
        s_cpol = 1'b0; s_cpha = 1'b0;
        stxq.push_back(W'($urandom()));
        @(negedge clock);
        p_start = 1'b1;
        @(negedge clock);
        p_start = 1'b0;
        repeat (11) @(negedge clock);
        check("abort busy_before", 32'(p_ready), 32'd0);
        reset = 1'b1;
        #1;
        check("abort cs", 32'(cs), 32'hF);
        check("abort sck", 32'(sck), 32'd0);
        check("abort ready", 32'(p_ready), 32'd1);
        @(negedge clock);
        reset = 1'b0;
        nd = 0;
        for (int c = 0; c < 50; c++) begin
            @(negedge clock);
            if (p_done === 1'b1) nd++;
        end
        check("abort no_done", 32'(nd), 32'd0);
        stxq.delete();
        srxq.delete();
        run_xfer(W'($urandom()), W'($urandom()), 1, 1'b0, 1'b0, 1'b0, 1'b0, "after_abort");

        for (int i = 0; i < 6; i++) begin
            mode = $urandom_range(0, 3);
            run_xfer(W'($urandom()), W'($urandom()), $urandom_range(0, 4),
                     mode[1], mode[0], 1'b0, 1'b0, $sformatf("rand%0d", i));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncomp, nfail);
        $finish;
    end

endmodule

// File: doc/spi_master_param.md
# spi_master_param

Parametrised SPI master: the successor to the fixed 8-bit, single-chip-select, mode-0 SPI module. It generates SCK from the system clock through a programmable divider and supports configurable word width, a configurable number of active-low chip selects, and all four CPOL/CPHA modes. The parallel side uses a start/ready/done handshake so a controller FSM or register bank can drive it directly. The block sits between on-chip logic and external SPI slaves.

## Interface
- `DATA_WIDTH`, default 8: bits per transfer, ≥2.
- `NUM_CS`, default 4: number of chip-select outputs, ≥1.
- `CLK_DIV`, default 2: system clocks per SCK half-period, ≥1.
- `CS_W`, default `$clog2(NUM_CS)` (minimum 1): width of `p_cs_sel`.

Ports:
- `clock` in 1: system clock; all logic on the rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `p_start` in 1: transfer request, sampled when `p_ready`=1.
- `p_ready` out 1: idle, able to accept `p_start`.
- `p_data_in` in DATA_WIDTH: transmit word, latched at accept.
- `p_data_out` out DATA_WIDTH: received word, valid from `p_done` until the next accept.
- `p_done` out 1: one-cycle pulse at end of transfer.
- `p_cs_sel` in CS_W: chip-select index, latched at accept.
- `p_cpol` in 1: clock polarity.
- `p_cpha` in 1: clock phase; both latched at accept.
- `sck` out 1: SPI clock.
- `mosi` out 1: serial data out, MSB first.
- `miso` in 1: serial data in.
- `cs` out NUM_CS: active-low chip selects.

## Operation
States:
- **IDLE**: `p_ready`=1. `sck` follows `p_cpol` with one register stage. An accept is `p_start`=1 in IDLE; it latches data, select, CPOL and CPHA, then goes to SETUP.
- **SETUP**: `cs[sel]`=0 and the MSB is on `mosi`. Lasts CLK_DIV cycles, then goes to SHIFT.
- **SHIFT**: 2·DATA_WIDTH SCK edges, one every CLK_DIV cycles.
  - CPHA=0: sample `miso` on odd (leading) edges; shift `mosi` on even (trailing) edges, except after the final edge.
  - CPHA=1: shift `mosi` on leading edges (the first leading edge presents the MSB); sample on trailing edges.
  - After the last edge, go to HOLD.
- **HOLD**: `sck` at CPOL and `cs` still asserted for CLK_DIV cycles. Then `cs` goes all-ones, `p_done` pulses, `p_data_out` updates, and the FSM returns to IDLE.

Rules:
- `p_start` while busy is ignored; it is not queued.
- `p_cs_sel` ≥ NUM_CS: the transfer runs normally with no `cs` bit asserted.
- Only one `cs` bit is ever low at a time.
- Receive shift register: LSB in, MSB out; `p_data_out` bit DATA_WIDTH-1 is the first bit sampled.
- Divider counter resets to 0 at every state entry.

## Timing
Reset values:
- `sck`=0, `mosi`=0, `cs`=all ones, `p_ready`=1, `p_done`=0, `p_data_out`=0.
- Reset asserted mid-transfer aborts immediately (asynchronous). No `p_done` is produced.

Transfer timeline (W = DATA_WIDTH, D = CLK_DIV, accept at cycle 0):
- Cycle 1: `cs` low, `p_ready`=0.
- Cycle 1+k·D: SCK edge k, for k=1..2W.
- Cycle 1+(2W+1)·D: `cs` high, `p_done`=1, `p_ready`=1.

Back-to-back transfers:
- `p_start` held high during the `p_done` cycle is accepted in that cycle.
- `cs` is then high for exactly one cycle before the next SETUP.
- Changing `p_cpol` between transfers moves `sck` one cycle after IDLE is entered, or at the next accept.

## Configuration
- `SPI_LOOPBACK_EN` defined:
  - Adds input port `p_loopback` (1 bit).
  - When it is 1, the receive path samples internal `mosi` instead of `miso`, and `sck` and `cs` still toggle.
- `SPI_LOOPBACK_EN` undefined:
  - The port is absent and `miso` is always sampled.
  - No loopback logic is synthesised.

## Test plan
- Reset release, then idle for 10 cycles → `cs`=4'b1111, `p_ready`=1, `sck`=0, `p_done`=0.
- W=8, D=2, mode 0, `p_data_in`=8'hE9, `p_cs_sel`=1, slave model returns 8'h5A:
  - `cs`=4'b1101 from cycle 1 to cycle 34.
  - `mosi` carries 1,1,1,0,1,0,0,1 on the leading edges.
  - `p_done` in cycle 35 with `p_data_out`=8'h5A.
- Modes 1, 2 and 3 with loopback (`SPI_LOOPBACK_EN`, `p_loopback`=1), tx 8'hE9 → `p_data_out`=8'hE9 each time, and `sck` idles at CPOL.
- Back-to-back: two accepts, 8'hE9 then 8'h17, with `p_start` held → `cs` high for exactly 1 cycle between transfers, and two `p_done` pulses 35 cycles apart.
- `p_start` pulsed during SHIFT → ignored, and exactly one `p_done`. `p_cs_sel`=5 with NUM_CS=4 → `cs` stays all ones, and `p_done` still occurs at cycle 35.
- Reset asserted at cycle 12 of a transfer → same cycle: `cs` all ones, `sck`=0, `p_ready`=1. No `p_done` follows, and the next transfer completes correctly.
